mmio_fifo_bank: RTL
===================

// Module: mmio_fifo_bank
// PURPOSE
//  NUM_CH independent FIFOs exposed over decoded CCI-P MMIO. Host MMIO writes push, host MMIO reads pop.
//  Per-channel status and clear registers are also MMIO-mapped.
//  Sits between the AFU's MMIO decode (Rx c0 mmio hdr/data) and its Tx c2 read-response path.
//  Does not own the DFH/AFU_ID addresses.
// PARAMETERS
//  NUM_CH     4         number of FIFO channels, 1..8
//  DEPTH      8         entries per channel, power of 2, >=2
//  WIDTH      64        data bits per entry, 1..64
//  DATA_BASE  16'h0020  channel c data reg at DATA_BASE+2*c (64-bit regs on even dword addrs)
//  STAT_BASE  16'h0040  channel c status reg at STAT_BASE+2*c (read-only)
//  CTRL_ADDR  16'h0060  write-only clear register
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, asynchronous, active-high
//  wr_valid   in   1       MMIO write strobe (rx.c0.mmioWrValid)
//  wr_addr    in   16      MMIO write dword address
//  wr_data    in   64      MMIO write data
//  rd_valid   in   1       MMIO read strobe (rx.c0.mmioRdValid)
//  rd_addr    in   16      MMIO read dword address
//  rd_tid     in   9       MMIO read transaction id
//  hit        out  1       comb: rd_addr decodes to a data/status reg of this block
//  rsp_valid  out  1       read response valid (one cycle)
//  rsp_tid    out  9       echoed rd_tid
//  rsp_data   out  64      read response data
// BEHAVIOUR
//  Reset: rst is asynchronous, active-high; clock is clk.
//   - Reset clears all pointers, counts and sticky flags.
//   - Outputs during reset: rsp_valid=0, rsp_tid=0, rsp_data=0.
//   - Reset mid-operation discards all FIFO contents. Any read in flight gets no response.
//  Push: wr_valid && wr_addr==DATA_BASE+2*c.
//   - wr_data[WIDTH-1:0] is enqueued.
//   - If full (and no same-cycle pop on c): the write is dropped and ovf[c] is set (sticky).
//  Pop: rd_valid && rd_addr==DATA_BASE+2*c.
//   - Response next cycle: rsp_valid=1, rsp_tid=rd_tid, rsp_data=zero-extended head. The head is dequeued.
//   - If empty: rsp_data=0, unf[c] is set (sticky), pointers unchanged.
//  Status read (rd_addr==STAT_BASE+2*c): 1-cycle response, no side effects.
//   - [0] empty, [1] full, [2] ovf, [3] unf, [31:16] count (0..DEPTH), all other bits 0.
//  Clear: write to CTRL_ADDR.
//   - wr_data[c]=1 flushes channel c: pointers, count, ovf and unf all go to 0.
//   - Bits >=NUM_CH are ignored.
//  Unmapped read address: rsp_valid=0, hit=0. The AFU top returns 0 for that read.
//  Latency: every hit read gets rsp_valid exactly 1 cycle after rd_valid. Back-to-back reads are supported every cycle.
//  Simultaneous push+pop on the same channel:
//   - When full: both succeed, count unchanged, no ovf.
//   - When empty: pop underflows (no bypass) and the push is accepted, so count=1.
//  Clear + pop on the same channel in the same cycle:
//   - The response returns the pre-clear head (0 + unf if empty).
//   - Clear then wins: end state is empty, flags 0.
//  Counts and pointers use $clog2(DEPTH)+1 bits and wrap modulo DEPTH. Full means count==DEPTH.
//  Only one MMIO write and one MMIO read arrive per cycle; they may target different regs in the same cycle.
// STRUCTURE
//  mmio_fifo_pkg:
//   - status bit positions (ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_UNF=3, ST_CNT_LSB=16)
//   - t_mmio_rsp struct {valid, tid[8:0], data[63:0]}
//   - default address localparams
//  Sub-module mmio_fifo_chan (one per channel, generate loop):
//   - ports: clk, rst, push, pop, clr, din, dout, count, full, empty, ovf, unf
//   - storage is a registered array; dout is the comb head
//  Top holds the address decode, response mux and response register.
// TESTING
//  1. Reset, then read STAT_BASE -> rsp 1 cycle later, data=64'h1 (empty), rsp_tid echoes; no other rsp.
//  2. Push 0xA,0xB,0xC to ch0, then 3 reads of DATA_BASE -> rsp_data 0xA,0xB,0xC in order, 1-cycle latency each.
//  3. DEPTH=8: push 9 words to ch1 -> status count=8, full=1, ovf=1; 8 pops return words 1..8; 9th pop returns 0 with unf=1.
//  4. ch2 full, push+pop same cycle -> head returned, count stays 8, ovf=0.
//     ch2 empty, push+pop same cycle -> rsp_data=0, unf=1, count=1.
//  5. Write CTRL_ADDR=4'b0101 with ch0 and ch2 non-empty -> ch0/ch2 status=1 (empty, flags clear); ch1/ch3 untouched.
//  6. Assert rst mid-burst with 4 entries queued -> rsp_valid=0 immediately; after release all channels read empty.
//     Also: read at unmapped 16'h0070 -> hit=0, no rsp.

Source files
------------

// File: rtl/mmio_fifo_pkg.sv
// Purpose: shared types, status bit map and address helpers for the MMIO FIFO bank.
// Latency: n/a (declarations only).
// Backpressure: n/a; MMIO has no flow control, overflow/underflow are flagged instead.
package mmio_fifo_pkg;

    // Status register bit positions
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_UNF     = 3;
    localparam int ST_CNT_LSB = 16;

    // Default register map (dword addresses; 64-bit regs sit on even dwords)
    localparam logic [15:0] DEF_DATA_BASE = 16'h0020;
    localparam logic [15:0] DEF_STAT_BASE = 16'h0040;
    localparam logic [15:0] DEF_CTRL_ADDR = 16'h0060;

    // Registered MMIO read response
    typedef struct packed {
        logic        valid;
        logic [8:0]  tid;
        logic [63:0] data;
    } t_mmio_rsp;

    // Dword address of register idx in a bank of 64-bit registers starting at base
    function automatic logic [15:0] reg_addr(input logic [15:0] base, input int unsigned idx);
        return base + 16'(idx << 1);
    endfunction

    // Pack one channel's status into the 64-bit status register layout
    function automatic logic [63:0] status_word(input logic        empty,
                                                input logic        full,
                                                input logic        ovf,
                                                input logic        unf,
                                                input logic [15:0] cnt);
        logic [63:0] w;
        w                   = '0;
        w[ST_EMPTY]         = empty;
        w[ST_FULL]          = full;
        w[ST_OVF]           = ovf;
        w[ST_UNF]           = unf;
        w[ST_CNT_LSB +: 16] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/mmio_fifo_chan.sv
// Purpose: one FIFO channel with sticky overflow/underflow flags and synchronous flush.
// Latency: push/pop take effect at the next clk edge; dout is the combinational head.
// Backpressure: none; push while full is dropped (ovf), pop while empty is ignored (unf).
module mmio_fifo_chan #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     unf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             pop_ok, push_ok;

    // Pointers advance modulo DEPTH
    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == CW'(DEPTH - 1)) ? '0 : p + CW'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign dout  = mem_q[rd_ptr_q[PW-1:0]];

    // Next-state: a pop frees a slot for a same-cycle push; an empty pop never bypasses
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push && !push_ok);
        unf_d    = unf_q | (pop && empty);
        if (push_ok) begin
            mem_d[wr_ptr_q[PW-1:0]] = din;
            wr_ptr_d                = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Flush overrides any same-cycle push/pop effect on state
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end
    end

    // Control state; cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Entry storage; contents are meaningless while count is 0, so no reset needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mmio_fifo_bank.sv
// Purpose: NUM_CH FIFOs behind CCI-P MMIO; writes push, reads pop, plus status and clear regs.
// Latency: every decoded read returns rsp_valid exactly one cycle after rd_valid.
// Backpressure: none; one read and one write per cycle, errors are reported via sticky flags.
module mmio_fifo_bank
    import mmio_fifo_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          DEPTH     = 8,
    parameter int          WIDTH     = 64,
    parameter logic [15:0] DATA_BASE = DEF_DATA_BASE,
    parameter logic [15:0] STAT_BASE = DEF_STAT_BASE,
    parameter logic [15:0] CTRL_ADDR = DEF_CTRL_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [15:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic        rd_valid,
    input  logic [15:0] rd_addr,
    input  logic [8:0]  rd_tid,
    output logic        hit,
    output logic        rsp_valid,
    output logic [8:0]  rsp_tid,
    output logic [63:0] rsp_data
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0] ch_push, ch_pop, ch_clr;
    logic [NUM_CH-1:0] ch_full, ch_empty, ch_ovf, ch_unf;
    logic [WIDTH-1:0]  ch_dout  [NUM_CH];
    logic [CW-1:0]     ch_count [NUM_CH];
    t_mmio_rsp         rsp_d, rsp_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mmio_fifo_chan #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .push  (ch_push[c]),
            .pop   (ch_pop[c]),
            .clr   (ch_clr[c]),
            .din   (wr_data[WIDTH-1:0]),
            .dout  (ch_dout[c]),
            .count (ch_count[c]),
            .full  (ch_full[c]),
            .empty (ch_empty[c]),
            .ovf   (ch_ovf[c]),
            .unf   (ch_unf[c])
        );
    end

    // Address decode and read-response mux; data/status reflect pre-edge channel state
    always_comb begin
        ch_push = '0;
        ch_pop  = '0;
        ch_clr  = '0;
        hit     = 1'b0;
        rsp_d   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_valid && (wr_addr == reg_addr(DATA_BASE, c))) begin
                ch_push[c] = 1'b1;
            end
            if (wr_valid && (wr_addr == CTRL_ADDR)) begin
                ch_clr[c] = wr_data[c];
            end
            if (rd_addr == reg_addr(DATA_BASE, c)) begin
                hit = 1'b1;
                if (rd_valid) begin
                    ch_pop[c]   = 1'b1;
                    rsp_d.valid = 1'b1;
                    rsp_d.tid   = rd_tid;
                    if (!ch_empty[c]) begin
                        rsp_d.data[WIDTH-1:0] = ch_dout[c];
                    end
                end
            end
            if (rd_addr == reg_addr(STAT_BASE, c)) begin
                hit = 1'b1;
                if (rd_valid) begin
                    rsp_d.valid = 1'b1;
                    rsp_d.tid   = rd_tid;
                    rsp_d.data  = status_word(ch_empty[c], ch_full[c], ch_ovf[c],
                                              ch_unf[c], 16'(ch_count[c]));
                end
            end
        end
    end

    // Response register; reset drops any read in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign rsp_valid = rsp_q.valid;
    assign rsp_tid   = rsp_q.tid;
    assign rsp_data  = rsp_q.data;

endmodule
